// File: rtl/commit_queue_pkg.sv
// Shared types for the commit queue: scoreboard entries, exceptions, per-slot state
// and a small popcount helper for the commit acknowledge vector.
package commit_queue_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned NR_SB_ENTRIES = 8;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned CNT_BITS      = TRANS_ID_BITS + 1;

    typedef enum logic [2:0] {
        FuNone,
        FuLoad,
        FuStore,
        FuAlu,
        FuCtrlFlow,
        FuMult,
        FuCsr,
        FuFpu
    } fu_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        scoreboard_entry_t sbe;
    } cq_slot_t;

    // Commit ports are limited to two, so the ack vector is at most two bits wide.
    function automatic logic [CNT_BITS-1:0] popcount(input logic [1:0] v);
        return CNT_BITS'(v[0]) + CNT_BITS'(v[1]);
    endfunction

endpackage

// File: rtl/commit_queue.sv
// In-order retirement buffer: allocates slots at issue, collects writeback results
// and presents the oldest completed entries to the commit stage.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 2,
    parameter int unsigned NR_ENTRIES      = NR_SB_ENTRIES
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       flush_i,
    input  logic                                       issue_valid_i,
    output logic                                       issue_ready_o,
    input  scoreboard_entry_t                          issue_entry_i,
    output logic [TRANS_ID_BITS-1:0]                   issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                     wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]           wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]               wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]    commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_ack_i
);

    logic [TRANS_ID_BITS-1:0] head_q, head_d;
    logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0]      count_q, count_d;
    logic [NR_ENTRIES-1:0]    busy_q;
    logic [NR_ENTRIES-1:0]    done_q;
    scoreboard_entry_t        sbe_q [NR_ENTRIES];
    cq_slot_t                 slots_d [NR_ENTRIES];

    logic                     issue_fire;
    logic [1:0]               ack_vec;
    logic [TRANS_ID_BITS-1:0] commit_idx [NR_COMMIT_PORTS];

    assign issue_ready_o    = (count_q != CNT_BITS'(NR_ENTRIES));
    assign issue_fire       = issue_valid_i & issue_ready_o;
    assign issue_trans_id_o = tail_q;

    always_comb begin
        ack_vec = '0;
        ack_vec[NR_COMMIT_PORTS-1:0] = commit_ack_i;
    end

    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_idx[i] = head_q + TRANS_ID_BITS'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_instr_o[i]          = sbe_q[commit_idx[i]];
            commit_instr_o[i].valid    = busy_q[commit_idx[i]] & done_q[commit_idx[i]];
            commit_instr_o[i].trans_id = commit_idx[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            slots_d[i].busy = busy_q[i];
            slots_d[i].done = done_q[i];
            slots_d[i].sbe  = sbe_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_BITS'(issue_fire) - popcount(ack_vec);

        if (issue_fire) begin
            slots_d[tail_q].busy         = 1'b1;
            // Fetch/decode faults never reach an FU, so they are complete on arrival.
            slots_d[tail_q].done         = issue_entry_i.ex.valid;
            slots_d[tail_q].sbe          = issue_entry_i;
            slots_d[tail_q].sbe.trans_id = tail_q;
            tail_d                       = tail_q + 1'b1;
        end

        // Walk ports high to low so the lowest index wins on a (disallowed) collision.
        for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && busy_q[wb_trans_id_i[p]]) begin
                slots_d[wb_trans_id_i[p]].done       = 1'b1;
                slots_d[wb_trans_id_i[p]].sbe.result = wb_result_i[p];
                if (wb_ex_i[p].valid) begin
                    slots_d[wb_trans_id_i[p]].sbe.ex = wb_ex_i[p];
                end else begin
                    // FPU status flags travel in cause even without an exception.
                    slots_d[wb_trans_id_i[p]].sbe.ex.cause = wb_ex_i[p].cause;
                end
            end
        end

        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i]) begin
                slots_d[commit_idx[i]].busy = 1'b0;
                slots_d[commit_idx[i]].done = 1'b0;
            end
        end
        head_d = head_q + TRANS_ID_BITS'(popcount(ack_vec));

        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                slots_d[i].busy = 1'b0;
                slots_d[i].done = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                busy_q[i] <= slots_d[i].busy;
                done_q[i] <= slots_d[i].done;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            sbe_q[i] <= slots_d[i].sbe;
        end
    end

    assert property (@(posedge clk_i) NR_ENTRIES == (1 << TRANS_ID_BITS));

    for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : gen_ack_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            commit_ack_i[i] |-> commit_instr_o[i].valid);
        if (i > 0) begin : gen_prefix
            assert property (@(posedge clk_i) disable iff (!rst_ni)
                commit_ack_i[i] |-> commit_ack_i[i-1]);
        end
    end

    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : gen_wb_chk
        for (genvar q = p + 1; q < NR_WB_PORTS; q++) begin : gen_pair
            assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(wb_valid_i[p] && wb_valid_i[q] && (wb_trans_id_i[p] == wb_trans_id_i[q])));
        end
    end

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue: issue, writeback, commit, wrap, flush and reset.
module tb_commit_queue;
    import commit_queue_pkg::*;

    logic                               clk;
    logic                               rst_n;
    logic                               flush;
    logic                               issue_valid;
    logic                               issue_ready;
    scoreboard_entry_t                  issue_entry;
    logic [TRANS_ID_BITS-1:0]           issue_trans_id;
    logic [1:0]                         wb_valid;
    logic [1:0][TRANS_ID_BITS-1:0]      wb_trans_id;
    logic [1:0][XLEN-1:0]               wb_result;
    exception_t [1:0]                   wb_ex;
    scoreboard_entry_t [1:0]            commit_instr;
    logic [1:0]                         commit_ack;

    int checks = 0;
    int errors = 0;

    commit_queue #(
        .NR_COMMIT_PORTS(2),
        .NR_WB_PORTS    (2),
        .NR_ENTRIES     (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .issue_entry_i   (issue_entry),
        .issue_trans_id_o(issue_trans_id),
        .wb_valid_i      (wb_valid),
        .wb_trans_id_i   (wb_trans_id),
        .wb_result_i     (wb_result),
        .wb_ex_i         (wb_ex),
        .commit_instr_o  (commit_instr),
        .commit_ack_i    (commit_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic scoreboard_entry_t mk_entry(input logic [XLEN-1:0] pc, input logic exv,
                                                   input logic [XLEN-1:0] cause);
        scoreboard_entry_t e;
        e          = '0;
        e.pc       = pc;
        e.fu       = FuAlu;
        e.op       = 8'h01;
        e.rd       = 5'd3;
        e.ex.valid = exv;
        e.ex.cause = cause;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        wb_valid    = '0;
        commit_ack  = '0;
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_entry = '0;
        wb_valid    = '0;
        wb_trans_id = '0;
        wb_result   = '0;
        wb_ex       = '0;
        commit_ack  = '0;
        #2;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", issue_ready);
        end
        checks++;
        if (issue_trans_id !== 3'd0) begin
            errors++; $display("FAIL reset_trans_id got %0d exp 0", issue_trans_id);
        end
        checks++;
        if (commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b exp 00",
                               commit_instr[1].valid, commit_instr[0].valid);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_issue();
        for (int k = 0; k < 3; k++) begin
            issue_entry = mk_entry(32'h80 + 32'(4 * k), 1'b0, '0);
            issue_valid = 1'b1;
            #1;
            checks++;
            if (issue_trans_id !== 3'(k)) begin
                errors++; $display("FAIL issue_id%0d got %0d exp %0d", k, issue_trans_id, k);
            end
            step();
        end
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b0) begin
            errors++; $display("FAIL issue_no_wb_valid got %b exp 0", commit_instr[0].valid);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL issue_ready got %b exp 1", issue_ready);
        end
    endtask

    task automatic test_writeback();
        wb_valid       = 2'b10;
        wb_trans_id[1] = 3'd1;
        wb_result[1]   = 32'h11;
        wb_ex[1]       = '0;
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b1) begin
            errors++; $display("FAIL wb_slot1_only got p0=%b p1=%b exp p0=0 p1=1",
                               commit_instr[0].valid, commit_instr[1].valid);
        end
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd0;
        wb_result[0]   = 32'h10;
        wb_ex[0]       = '0;
        #1;
        checks++;
        if (commit_instr[0].valid !== 1'b0) begin
            errors++; $display("FAIL wb_latency got %b exp 0", commit_instr[0].valid);
        end
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b1 || commit_instr[0].pc !== 32'h80 ||
            commit_instr[0].result !== 32'h10) begin
            errors++; $display("FAIL wb_port0 got v=%b pc=%h res=%h exp v=1 pc=80 res=10",
                               commit_instr[0].valid, commit_instr[0].pc, commit_instr[0].result);
        end
        checks++;
        if (commit_instr[1].valid !== 1'b1 || commit_instr[1].pc !== 32'h84 ||
            commit_instr[1].result !== 32'h11) begin
            errors++; $display("FAIL wb_port1 got v=%b pc=%h res=%h exp v=1 pc=84 res=11",
                               commit_instr[1].valid, commit_instr[1].pc, commit_instr[1].result);
        end
        commit_ack = 2'b11;
        step();
        idle();
        checks++;
        if (commit_instr[0].trans_id !== 3'd2 || commit_instr[0].valid !== 1'b0 ||
            commit_instr[0].pc !== 32'h88) begin
            errors++; $display("FAIL ack_head got id=%0d v=%b pc=%h exp id=2 v=0 pc=88",
                               commit_instr[0].trans_id, commit_instr[0].valid,
                               commit_instr[0].pc);
        end
        checks++;
        if (issue_trans_id !== 3'd3) begin
            errors++; $display("FAIL ack_tail got %0d exp 3", issue_trans_id);
        end
    endtask

    task automatic test_full();
        // One entry (slot 2) is live; seven more fill the queue and wrap the tail.
        for (int k = 0; k < 7; k++) begin
            issue_entry = mk_entry(32'h100 + 32'(4 * k), 1'b0, '0);
            issue_valid = 1'b1;
            #1;
            checks++;
            if (issue_trans_id !== 3'((3 + k) % 8) || issue_ready !== 1'b1) begin
                errors++; $display("FAIL fill%0d got id=%0d rdy=%b exp id=%0d rdy=1",
                                   k, issue_trans_id, issue_ready, (3 + k) % 8);
            end
            step();
        end
        idle();
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b exp 0", issue_ready);
        end
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd2;
        wb_result[0]   = 32'h22;
        step();
        idle();
        issue_entry = mk_entry(32'h1ff, 1'b0, '0);
        issue_valid = 1'b1;
        commit_ack  = 2'b01;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || commit_instr[0].valid !== 1'b1) begin
            errors++; $display("FAIL full_ack_same got rdy=%b v=%b exp rdy=0 v=1",
                               issue_ready, commit_instr[0].valid);
        end
        step();
        idle();
        checks++;
        if (issue_ready !== 1'b1 || issue_trans_id !== 3'd2) begin
            errors++; $display("FAIL full_after got rdy=%b id=%0d exp rdy=1 id=2",
                               issue_ready, issue_trans_id);
        end
        checks++;
        if (commit_instr[0].trans_id !== 3'd3) begin
            errors++; $display("FAIL full_head got %0d exp 3", commit_instr[0].trans_id);
        end
    endtask

    task automatic test_flush();
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd3;
        wb_result[0]   = 32'h33;
        step();
        idle();
        flush          = 1'b1;
        issue_entry    = mk_entry(32'h900, 1'b1, 32'd2);
        issue_valid    = 1'b1;
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd4;
        commit_ack     = 2'b01;
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %b%b exp 00",
                               commit_instr[1].valid, commit_instr[0].valid);
        end
        checks++;
        if (issue_trans_id !== 3'd0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ptr got id=%0d rdy=%b exp id=0 rdy=1",
                               issue_trans_id, issue_ready);
        end
    endtask

    task automatic test_exception();
        issue_entry = mk_entry(32'h200, 1'b1, 32'd12);
        issue_valid = 1'b1;
        #1;
        checks++;
        if (issue_trans_id !== 3'd0) begin
            errors++; $display("FAIL ex_issue_id got %0d exp 0", issue_trans_id);
        end
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b1 || commit_instr[0].ex.valid !== 1'b1 ||
            commit_instr[0].ex.cause !== 32'd12 || commit_instr[0].pc !== 32'h200) begin
            errors++; $display("FAIL ex_commit got v=%b exv=%b cause=%0d pc=%h exp 1 1 12 200",
                               commit_instr[0].valid, commit_instr[0].ex.valid,
                               commit_instr[0].ex.cause, commit_instr[0].pc);
        end
        commit_ack = 2'b01;
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b0 || issue_trans_id !== 3'd1) begin
            errors++; $display("FAIL ex_ack got v=%b id=%0d exp v=0 id=1",
                               commit_instr[0].valid, issue_trans_id);
        end
    endtask

    task automatic test_wb_flags();
        issue_entry = mk_entry(32'h300, 1'b0, '0);
        issue_valid = 1'b1;
        step();
        idle();
        wb_valid       = 2'b10;
        wb_trans_id[1] = 3'd1;
        wb_result[1]   = 32'h33;
        wb_ex[1]       = '{cause: 32'd5, tval: '0, valid: 1'b0};
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b1 || commit_instr[0].ex.valid !== 1'b0 ||
            commit_instr[0].ex.cause !== 32'd5 || commit_instr[0].result !== 32'h33) begin
            errors++; $display("FAIL wb_flags got v=%b exv=%b cause=%0d res=%h exp 1 0 5 33",
                               commit_instr[0].valid, commit_instr[0].ex.valid,
                               commit_instr[0].ex.cause, commit_instr[0].result);
        end
        commit_ack = 2'b01;
        step();
        idle();
    endtask

    task automatic test_wb_free();
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd5;
        wb_result[0]   = 32'hdead;
        wb_ex[0]       = '0;
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b0) begin
            errors++; $display("FAIL wb_free_valid got %b%b exp 00",
                               commit_instr[1].valid, commit_instr[0].valid);
        end
        checks++;
        if (issue_trans_id !== 3'd2 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL wb_free_ptr got id=%0d rdy=%b exp id=2 rdy=1",
                               issue_trans_id, issue_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue_entry = mk_entry(32'h500, 1'b0, '0);
        issue_valid = 1'b1;
        step();
        issue_entry    = mk_entry(32'h504, 1'b0, '0);
        wb_valid       = 2'b01;
        wb_trans_id[0] = 3'd2;
        wb_result[0]   = 32'h55;
        step();
        issue_entry    = mk_entry(32'h508, 1'b0, '0);
        wb_trans_id[0] = 3'd3;
        commit_ack     = 2'b01;
        #1;
        checks++;
        if (commit_instr[0].valid !== 1'b1 || commit_instr[0].pc !== 32'h500) begin
            errors++; $display("FAIL b2b_first got v=%b pc=%h exp v=1 pc=500",
                               commit_instr[0].valid, commit_instr[0].pc);
        end
        step();
        idle();
        checks++;
        if (commit_instr[0].valid !== 1'b1 || commit_instr[0].pc !== 32'h504 ||
            commit_instr[0].trans_id !== 3'd3) begin
            errors++; $display("FAIL b2b_second got v=%b pc=%h id=%0d exp v=1 pc=504 id=3",
                               commit_instr[0].valid, commit_instr[0].pc,
                               commit_instr[0].trans_id);
        end
        checks++;
        if (issue_trans_id !== 3'd5 || commit_instr[1].valid !== 1'b0) begin
            errors++; $display("FAIL b2b_tail got id=%0d p1v=%b exp id=5 p1v=0",
                               issue_trans_id, commit_instr[1].valid);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || issue_trans_id !== 3'd0 ||
            commit_instr[0].valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rdy=%b id=%0d v=%b exp rdy=1 id=0 v=0",
                               issue_ready, issue_trans_id, commit_instr[0].valid);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (issue_ready !== 1'b1 || issue_trans_id !== 3'd0) begin
            errors++; $display("FAIL post_reset got rdy=%b id=%0d exp rdy=1 id=0",
                               issue_ready, issue_trans_id);
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_writeback();
        test_full();
        test_flush();
        test_exception();
        test_wb_flags();
        test_wb_free();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
